// File: rtl/mcu_el2_lsu_dccm_mem_mp.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_el2_lsu_dccm_mem_mp
//  Description : Multi-channel banked DCCM front-end. NUM_CH requestors issue
//                aligned or bank-unaligned (lo/hi pair) reads and writes. The
//                block arbitrates bank conflicts round-robin, drives the RAM
//                banks and returns per-channel lo/hi read data.
//
//  Ports       : clk, rst (sync, active-high), clk_override
//                ch_valid/ch_ready/ch_we, ch_addr_lo/hi, ch_wdata_lo/hi
//                ch_rvalid, ch_rdata_lo/hi (held while ch_rvalid is low)
//                bank_clken/bank_wren/bank_addr/bank_wdata, bank_dout
//
//  Config      : MCU_DCCM_MP_OUT_REG_EN - when defined, adds an output
//                register on ch_rvalid/ch_rdata_*, giving read latency 2.
//                Otherwise read latency is 1.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mcu_el2_lsu_dccm_mem_mp #(
    parameter int   NUM_CH    = 2,
    parameter int   NUM_BANKS = 8,
    parameter int   INDEX_W   = 11,
    parameter int   FDATA_W   = 39,
    localparam int  BANK_BITS = $clog2(NUM_BANKS),
    localparam int  ADDR_W    = INDEX_W + BANK_BITS + 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clk_override,
    input  logic [NUM_CH-1:0]                   ch_valid,
    output logic [NUM_CH-1:0]                   ch_ready,
    input  logic [NUM_CH-1:0]                   ch_we,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]       ch_addr_lo,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]       ch_addr_hi,
    input  logic [NUM_CH-1:0][FDATA_W-1:0]      ch_wdata_lo,
    input  logic [NUM_CH-1:0][FDATA_W-1:0]      ch_wdata_hi,
    output logic [NUM_CH-1:0]                   ch_rvalid,
    output logic [NUM_CH-1:0][FDATA_W-1:0]      ch_rdata_lo,
    output logic [NUM_CH-1:0][FDATA_W-1:0]      ch_rdata_hi,
    output logic [NUM_BANKS-1:0]                bank_clken,
    output logic [NUM_BANKS-1:0]                bank_wren,
    output logic [NUM_BANKS-1:0][INDEX_W-1:0]   bank_addr,
    output logic [NUM_BANKS-1:0][FDATA_W-1:0]   bank_wdata,
    input  logic [NUM_BANKS-1:0][FDATA_W-1:0]   bank_dout
);

    localparam int C_CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // ------------------------------------------------------------------
    // Request decode: bank pair, row pair and touched-bank mask
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0][BANK_BITS-1:0] w_bank_lo;
    logic [NUM_CH-1:0][BANK_BITS-1:0] w_bank_hi;
    logic [NUM_CH-1:0][INDEX_W-1:0]   w_row_lo;
    logic [NUM_CH-1:0][INDEX_W-1:0]   w_row_hi;
    logic [NUM_CH-1:0][NUM_BANKS-1:0] w_set;
    logic [NUM_CH-1:0]                w_unal;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_bank_lo[c] = ch_addr_lo[c][2 +: BANK_BITS];
            w_bank_hi[c] = ch_addr_hi[c][2 +: BANK_BITS];
            w_row_lo[c]  = ch_addr_lo[c][ADDR_W-1 -: INDEX_W];
            w_row_hi[c]  = ch_addr_hi[c][ADDR_W-1 -: INDEX_W];
            w_set[c]     = '0;
            w_set[c][w_bank_lo[c]] = 1'b1;
            w_set[c][w_bank_hi[c]] = 1'b1;
            w_unal[c]    = (w_bank_lo[c] != w_bank_hi[c]);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin, all-or-nothing grant. Channels are visited starting at
    // r_rr_ptr; a channel wins only if none of its banks is already taken.
    // The last channel granted in the walk is the lowest-priority winner,
    // and the pointer moves just past it when somebody had to wait.
    // ------------------------------------------------------------------
    logic [C_CH_BITS-1:0] r_rr_ptr;
    logic [C_CH_BITS-1:0] w_rr_next;
    logic [NUM_CH-1:0]    w_grant;
    logic                 w_any_denied;

    always_comb begin
        logic [NUM_BANKS-1:0] v_used;
        int                   v_idx;
        v_used       = '0;
        v_idx        = 0;
        w_grant      = '0;
        w_any_denied = 1'b0;
        w_rr_next    = r_rr_ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NUM_CH;
            // Grants during reset are suppressed so no bank is touched.
            if (ch_valid[v_idx] && !rst) begin
                if ((w_set[v_idx] & v_used) == '0) begin
                    w_grant[v_idx] = 1'b1;
                    v_used         = v_used | w_set[v_idx];
                    w_rr_next      = C_CH_BITS'((v_idx + 1) % NUM_CH);
                end else begin
                    w_any_denied = 1'b1;
                end
            end
        end
    end

    assign ch_ready = w_grant;

    // ------------------------------------------------------------------
    // Bank drive. Granted sets never overlap, so each bank has at most one
    // owner. Only the hi bank of an unaligned request uses the hi row/data.
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0] w_access;

    always_comb begin
        w_access   = '0;
        bank_wren  = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_grant[c] && w_set[c][b]) begin
                    w_access[b]  = 1'b1;
                    bank_wren[b] = ch_we[c];
                    if (w_unal[c] && (b == int'(w_bank_hi[c]))) begin
                        bank_addr[b]  = w_row_hi[c];
                        bank_wdata[b] = ch_wdata_hi[c];
                    end else begin
                        bank_addr[b]  = w_row_lo[c];
                        bank_wdata[b] = ch_wdata_lo[c];
                    end
                end
            end
        end
    end

    assign bank_clken = w_access | {NUM_BANKS{clk_override}};

    // ------------------------------------------------------------------
    // Arbitration state and read tracking (bank indices captured at grant)
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]                r_rd_pend;
    logic [NUM_CH-1:0][BANK_BITS-1:0] r_lo_idx;
    logic [NUM_CH-1:0][BANK_BITS-1:0] r_hi_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_rd_pend <= '0;
            r_lo_idx  <= '0;
            r_hi_idx  <= '0;
        end else begin
            if (w_any_denied) begin
                r_rr_ptr <= w_rr_next;
            end
            r_rd_pend <= w_grant & ~ch_we;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_grant[c] && !ch_we[c]) begin
                    r_lo_idx[c] <= w_bank_lo[c];
                    r_hi_idx[c] <= w_bank_hi[c];
                end
            end
        end
    end

    // A read granted just before reset must not report data.
    logic [NUM_CH-1:0]              w_rvalid;
    logic [NUM_CH-1:0][FDATA_W-1:0] w_rd_lo;
    logic [NUM_CH-1:0][FDATA_W-1:0] w_rd_hi;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_rvalid[c] = r_rd_pend[c] & ~rst;
            w_rd_lo[c]  = bank_dout[r_lo_idx[c]];
            w_rd_hi[c]  = bank_dout[r_hi_idx[c]];
        end
    end

    // Holding registers: output data keeps its last value when rvalid is low.
    logic [NUM_CH-1:0][FDATA_W-1:0] r_hold_lo;
    logic [NUM_CH-1:0][FDATA_W-1:0] r_hold_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_lo <= '0;
            r_hold_hi <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_rvalid[c]) begin
                    r_hold_lo[c] <= w_rd_lo[c];
                    r_hold_hi[c] <= w_rd_hi[c];
                end
            end
        end
    end

`ifdef MCU_DCCM_MP_OUT_REG_EN
    // Registered outputs: the holding registers double as the data stage.
    logic [NUM_CH-1:0] r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= '0;
        end else begin
            r_out_valid <= w_rvalid;
        end
    end

    assign ch_rvalid   = r_out_valid;
    assign ch_rdata_lo = r_hold_lo;
    assign ch_rdata_hi = r_hold_hi;
`else
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_rdata_lo[c] = w_rvalid[c] ? w_rd_lo[c] : r_hold_lo[c];
            ch_rdata_hi[c] = w_rvalid[c] ? w_rd_hi[c] : r_hold_hi[c];
        end
    end

    assign ch_rvalid = w_rvalid;
`endif

    // Word-offset address bits carry no meaning for the banks.
    logic w_unused;
    assign w_unused = ^{ch_addr_lo, ch_addr_hi};

endmodule
`default_nettype wire

// File: tb/tb_mcu_el2_lsu_dccm_mem_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcu_el2_lsu_dccm_mem_mp
//  Description : Directed self-checking bench for mcu_el2_lsu_dccm_mem_mp
//                (2 channels, 8 banks, 11-bit rows, 39-bit words).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_el2_lsu_dccm_mem_mp;

    localparam int NUM_CH    = 2;
    localparam int NUM_BANKS = 8;
    localparam int INDEX_W   = 11;
    localparam int FDATA_W   = 39;
    localparam int ADDR_W    = 16;

    logic                               clk = 1'b0;
    logic                               rst;
    logic                               clk_override;
    logic [NUM_CH-1:0]                  ch_valid;
    logic [NUM_CH-1:0]                  ch_ready;
    logic [NUM_CH-1:0]                  ch_we;
    logic [NUM_CH-1:0][ADDR_W-1:0]      ch_addr_lo;
    logic [NUM_CH-1:0][ADDR_W-1:0]      ch_addr_hi;
    logic [NUM_CH-1:0][FDATA_W-1:0]     ch_wdata_lo;
    logic [NUM_CH-1:0][FDATA_W-1:0]     ch_wdata_hi;
    logic [NUM_CH-1:0]                  ch_rvalid;
    logic [NUM_CH-1:0][FDATA_W-1:0]     ch_rdata_lo;
    logic [NUM_CH-1:0][FDATA_W-1:0]     ch_rdata_hi;
    logic [NUM_BANKS-1:0]               bank_clken;
    logic [NUM_BANKS-1:0]               bank_wren;
    logic [NUM_BANKS-1:0][INDEX_W-1:0]  bank_addr;
    logic [NUM_BANKS-1:0][FDATA_W-1:0]  bank_wdata;
    logic [NUM_BANKS-1:0][FDATA_W-1:0]  bank_dout;

    mcu_el2_lsu_dccm_mem_mp #(
        .NUM_CH    (NUM_CH),
        .NUM_BANKS (NUM_BANKS),
        .INDEX_W   (INDEX_W),
        .FDATA_W   (FDATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_override (clk_override),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .ch_we        (ch_we),
        .ch_addr_lo   (ch_addr_lo),
        .ch_addr_hi   (ch_addr_hi),
        .ch_wdata_lo  (ch_wdata_lo),
        .ch_wdata_hi  (ch_wdata_hi),
        .ch_rvalid    (ch_rvalid),
        .ch_rdata_lo  (ch_rdata_lo),
        .ch_rdata_hi  (ch_rdata_hi),
        .bank_clken   (bank_clken),
        .bank_wren    (bank_wren),
        .bank_addr    (bank_addr),
        .bank_wdata   (bank_wdata),
        .bank_dout    (bank_dout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ch_valid    = '0;
        ch_we       = '0;
        ch_addr_lo  = '0;
        ch_addr_hi  = '0;
        ch_wdata_lo = '0;
        ch_wdata_hi = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Clock the granted read in, drop requests, wait out the read latency.
    task automatic settle_read(input string tag);
        step();
        idle();
`ifdef MCU_DCCM_MP_OUT_REG_EN
        #1 check({tag, "_lat2_gap"}, 64'(ch_rvalid), 64'h0);
        step();
`endif
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        clk_override = 1'b0;
        bank_dout    = '0;
        idle();

        // Reset: a write request must not reach any bank.
        @(negedge clk);
        ch_valid       = 2'b01;
        ch_we          = 2'b01;
        ch_addr_lo[0]  = 16'h0008;
        ch_addr_hi[0]  = 16'h0008;
        ch_wdata_lo[0] = 39'h1;
        #1 check("rst_wren",  64'(bank_wren),  64'h0);
        check("rst_clken", 64'(bank_clken), 64'h0);
        step();
        idle();
        rst = 1'b0;
        #1 check("rst_rvalid", 64'(ch_rvalid), 64'h0);
        check("rst_rdata_lo0", 64'(ch_rdata_lo[0]), 64'h0);
        check("rst_rdata_hi1", 64'(ch_rdata_hi[1]), 64'h0);

        // T1: aligned read, bank 4, row 0.
        bank_dout[4]  = 39'h1_2345_6789;
        ch_valid      = 2'b01;
        ch_addr_lo[0] = 16'h0010;
        ch_addr_hi[0] = 16'h0010;
        #1 check("t1_ready", 64'(ch_ready), 64'h1);
        check("t1_clken", 64'(bank_clken), 64'h10);
        check("t1_wren",  64'(bank_wren),  64'h0);
        check("t1_addr4", 64'(bank_addr[4]), 64'h0);
        settle_read("t1");
        check("t1_rvalid", 64'(ch_rvalid), 64'h1);
        check("t1_rdata_lo", 64'(ch_rdata_lo[0]), 64'h1_2345_6789);
        check("t1_rdata_hi", 64'(ch_rdata_hi[0]), 64'h1_2345_6789);

        // T2: unaligned read, lo bank 7 row 0, hi bank 0 row 1.
        bank_dout[7]  = 39'h0_AAAA_0007;
        bank_dout[0]  = 39'h0_5555_0000;
        ch_valid      = 2'b01;
        ch_addr_lo[0] = 16'h001C;
        ch_addr_hi[0] = 16'h0020;
        #1 check("t2_ready", 64'(ch_ready), 64'h1);
        check("t2_clken", 64'(bank_clken), 64'h81);
        check("t2_addr7", 64'(bank_addr[7]), 64'h0);
        check("t2_addr0", 64'(bank_addr[0]), 64'h1);
        settle_read("t2");
        check("t2_rvalid", 64'(ch_rvalid), 64'h1);
        check("t2_rdata_lo", 64'(ch_rdata_lo[0]), 64'h0_AAAA_0007);
        check("t2_rdata_hi", 64'(ch_rdata_hi[0]), 64'h0_5555_0000);
        step();
        #1 check("t2_idle_rvalid", 64'(ch_rvalid), 64'h0);
        check("t2_hold_lo", 64'(ch_rdata_lo[0]), 64'h0_AAAA_0007);
        check("t2_hold_hi", 64'(ch_rdata_hi[0]), 64'h0_5555_0000);

        // T3: ch0 writes bank 2 while ch1 reads bank 5.
        bank_dout[5]   = 39'h4_5555_0005;
        ch_valid       = 2'b11;
        ch_we          = 2'b01;
        ch_addr_lo[0]  = 16'h0008;
        ch_addr_hi[0]  = 16'h0008;
        ch_wdata_lo[0] = 39'h7_0000_BEEF;
        ch_addr_lo[1]  = 16'h0014;
        ch_addr_hi[1]  = 16'h0014;
        #1 check("t3_ready", 64'(ch_ready), 64'h3);
        check("t3_wren",  64'(bank_wren),  64'h04);
        check("t3_clken", 64'(bank_clken), 64'h24);
        check("t3_wdata2", 64'(bank_wdata[2]), 64'h7_0000_BEEF);
        settle_read("t3");
        check("t3_rvalid", 64'(ch_rvalid), 64'h2);
        check("t3_rdata_lo1", 64'(ch_rdata_lo[1]), 64'h4_5555_0005);
        check("t3_rdata_hi1", 64'(ch_rdata_hi[1]), 64'h4_5555_0005);

        // T4: both channels hammer bank 3 from reset -> alternate grants.
        rst = 1'b1;
        step();
        rst           = 1'b0;
        ch_valid      = 2'b11;
        ch_addr_lo[0] = 16'h000C;
        ch_addr_hi[0] = 16'h000C;
        ch_addr_lo[1] = 16'h000C;
        ch_addr_hi[1] = 16'h000C;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("t4_ready_c%0d", i), 64'(ch_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            step();
        end
        // Fifth conflicting cycle: ch0 wins and the pointer moves to 1.
        #1 check("t5_pre_ready", 64'(ch_ready), 64'h1);
        step();

        // T5: ch1 unaligned (banks 6,7) vs ch0 aligned bank 7 with rr_ptr=1.
        ch_addr_lo[1] = 16'h0018;
        ch_addr_hi[1] = 16'h001C;
        ch_addr_lo[0] = 16'h001C;
        ch_addr_hi[0] = 16'h001C;
        #1 check("t5_ready", 64'(ch_ready), 64'h2);
        check("t5_clken", 64'(bank_clken), 64'hC0);
        step();
        #1 check("t5_rr_back_to_0", 64'(ch_ready), 64'h1);
        step();
        idle();
        step();
        step();

        // T6: reset in the cycle after a read grant kills the response.
        ch_valid      = 2'b01;
        ch_addr_lo[0] = 16'h0010;
        ch_addr_hi[0] = 16'h0010;
        #1 check("t6_ready", 64'(ch_ready), 64'h1);
        step();
        idle();
        rst = 1'b1;
        #1 check("t6_rvalid_in_rst", 64'(ch_rvalid), 64'h0);
        step();
        rst = 1'b0;
        #1 check("t6_rvalid_after_rst", 64'(ch_rvalid), 64'h0);
        check("t6_rdata_after_rst", 64'(ch_rdata_lo[0]), 64'h0);
        step();
        #1 check("t6_rvalid_late", 64'(ch_rvalid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
